link_rx_packer: RTL and testbench
=================================

Name: link_rx_packer

Overview:
- Receive-side stage directly downstream of the link slave FSM.
- Consumes the slave's per-byte output: a strobe, the 8-bit byte and the last-byte flag.
- Packs bytes little-endian into 32-bit words, buffers them in a small FIFO, and presents them on a valid/ready stream with frame-end marking.
- Also provides a sticky overflow flag and a completed-frame counter for link_top-level status.

Parameters:
DEPTH, 4, FIFO depth in 32-bit words; power of two, >= 2.
CW, 16, width of the completed-frame counter.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
byte_valid  input  1  one-cycle strobe from the slave FSM: byte_in/last_byte valid this cycle.
byte_in  input  8  received data byte.
last_byte  input  1  qualifies byte_in as the final byte of a frame.
word_valid  output  1  FIFO head holds a word.
word_ready  input  1  consumer accepts the head word this cycle.
word_data  output  32  packed word; byte 0 in [7:0]; unused lanes are 0.
word_bytes  output  3  valid bytes in word_data, 1..4.
word_last  output  1  word ends a frame.
level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
ovf  output  1  sticky overflow flag.
ovf_clr  input  1  clears ovf.
frame_cnt  output  CW  count of last-words popped; wraps modulo 2^CW.

Behaviour:
- Reset (rst=0, asynchronous), all of the following:
  - lane index = 0 and packing register = 0.
  - FIFO empty: word_valid=0, level=0.
  - word_data=0, word_bytes=0, word_last=0.
  - ovf=0, frame_cnt=0.
- Packer: two implicit states, IDLE (lane index 0) and PACKING (lane index 1..3).
  - On byte_valid, byte_in is written to lane idx of the packing register.
  - If idx==3 or last_byte=1, the word completes this cycle:
    - push {word, idx+1, last_byte}; unused lanes forced to 0; idx returns to 0.
  - Otherwise idx increments.
  - byte_valid=0 leaves the packer unchanged; there is no timeout.
- Push/latency:
  - A completed word is written to the FIFO on the same clock edge as its completing byte.
  - word_valid and level update in the following cycle.
  - Latency from the completing byte_valid to word_valid=1 is 1 cycle.
  - No bypass: a push into an empty FIFO is never visible combinationally.
- Pop: occurs when word_valid && word_ready.
  - The head advances on that edge.
  - word_data, word_bytes and word_last hold stable while word_valid=1 and word_ready=0.
  - word_ready while word_valid=0 has no effect.
- Simultaneous push and pop:
  - Both are performed and level is unchanged.
  - This holds when the FIFO is full: the pop frees the slot and the push is accepted, with no overflow.
- Overflow:
  - Triggered by a push when level==DEPTH and no pop in the same cycle.
  - The completed word is dropped and ovf is set.
  - FIFO contents and pointers are untouched.
  - The packer still resets idx to 0, so the next byte starts a fresh word.
- ovf stays 1 until ovf_clr=1. If an overflow and ovf_clr occur in the same cycle, set wins.
- frame_cnt increments on each pop with word_last=1 and wraps to 0 after 2^CW-1.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level distinguishes full from empty.
- Reset mid-frame:
  - Partial packing-register contents and all FIFO words are discarded.
  - A new frame after reset starts at lane 0.
- last_byte without byte_valid is ignored.
- byte_valid is never asserted on consecutive cycles by the slave, but the packer accepts back-to-back strobes correctly.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 (last on 0x44), word_ready=1 -> one cycle after the 4th strobe: word_data=0x44332211, word_bytes=4, word_last=1; frame_cnt=1 after pop.
- Six bytes 0xA0..0xA5, last on 0xA5 -> word 0xA3A2A1A0 (bytes=4, last=0), then 0x0000A5A4 (bytes=2, last=1).
- word_ready=0, push DEPTH+1 full words -> level=4, ovf=1 on the 5th push. Draining returns the first 4 words in order. ovf_clr=1 -> ovf=0.
- FIFO full, word_ready=1 in the same cycle a word completes -> both accepted, level stays 4, ovf stays 0.
- Assert rst=0 after 2 bytes of a frame, release, send 0x01..0x04 with last -> word_data=0x04030201; no stale bytes; frame_cnt=1.
- Single byte 0x7E with last_byte=1 -> word_data=0x0000007E, word_bytes=1, word_last=1.

Source files
------------

// File: rtl/link_rx_packer_if.sv
// Bundle between the link slave FSM, the packer and the word consumer.
// Packer ports use slave; the driving side (slave FSM plus consumer) uses master.
interface link_rx_packer_if #(
  parameter int DEPTH = 4,
  parameter int CW    = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  // Byte side is a strobe with no back-pressure: byte_in/last_byte mean something
  // only in a cycle with byte_valid=1.
  // Word side is valid/ready: a transfer happens on the rising edge where
  // word_valid && word_ready. word_data/bytes/last hold while valid waits for ready.
  // ready without valid does nothing.
  logic          byte_valid;
  logic [7:0]    byte_in;
  logic          last_byte;
  logic          word_valid;
  logic          word_ready;
  logic [31:0]   word_data;
  logic [2:0]    word_bytes;
  logic          word_last;
  logic [LW-1:0] level;
  logic          ovf;
  logic          ovf_clr;
  logic [CW-1:0] frame_cnt;
  logic          dbg_packing;
  logic [1:0]    dbg_idx;

  modport master (
    output byte_valid, byte_in, last_byte, word_ready, ovf_clr,
    input  word_valid, word_data, word_bytes, word_last, level, ovf, frame_cnt,
           dbg_packing, dbg_idx
  );

  modport slave (
    input  byte_valid, byte_in, last_byte, word_ready, ovf_clr,
    output word_valid, word_data, word_bytes, word_last, level, ovf, frame_cnt,
           dbg_packing, dbg_idx
  );
endinterface

// File: rtl/link_rx_packer.sv
// Packs received link bytes little-endian into 32-bit words and queues them in a small
// FIFO behind a valid/ready stream. Also keeps a sticky overflow flag and a frame counter.
module link_rx_packer #(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  link_rx_packer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PACKING = 1'b1
  } pack_state_t;

  pack_state_t   r_state;
  pack_state_t   w_state_d;
  logic [1:0]    r_idx;
  logic [1:0]    w_idx_d;
  logic [31:0]   r_pack;
  logic [31:0]   w_pack_d;
  logic [31:0]   w_merged;
  logic          w_complete;
  logic [2:0]    w_bytes;

  logic [31:0]   r_mem_data  [DEPTH];
  logic [2:0]    r_mem_bytes [DEPTH];
  logic          r_mem_last  [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_ovf;
  logic [CW-1:0] r_frame_cnt;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_ovf_set;

  // Packer FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
      r_pack  <= 32'd0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_pack  <= w_pack_d;
    end
  end

  // Lanes above the current index are forced to zero here, so a short final word
  // never carries bytes from an earlier frame.
  always_comb begin
    w_state_d  = r_state;
    w_idx_d    = r_idx;
    w_pack_d   = r_pack;
    w_complete = 1'b0;
    case (r_idx)
      2'd0:    w_merged = {24'd0, bus.byte_in};
      2'd1:    w_merged = {16'd0, bus.byte_in, r_pack[7:0]};
      2'd2:    w_merged = {8'd0, bus.byte_in, r_pack[15:0]};
      default: w_merged = {bus.byte_in, r_pack[23:0]};
    endcase
    if (bus.byte_valid) begin
      if (r_idx == 2'd3 || bus.last_byte) begin
        w_complete = 1'b1;
        w_idx_d    = 2'd0;
        w_pack_d   = 32'd0;
        w_state_d  = ST_IDLE;
      end else begin
        w_idx_d    = r_idx + 2'd1;
        w_pack_d   = w_merged;
        w_state_d  = ST_PACKING;
      end
    end
  end

  assign w_bytes   = {1'b0, r_idx} + 3'd1;
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LW'(DEPTH));
  assign w_pop     = !w_empty && bus.word_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push    = w_complete && (!w_full || w_pop);
  assign w_ovf_set = w_complete && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr]  <= w_merged;
      r_mem_bytes[r_wptr] <= w_bytes;
      r_mem_last[r_wptr]  <= bus.last_byte;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Overflow set has priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (bus.ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= '0;
    end else if (w_pop && r_mem_last[r_rptr]) begin
      r_frame_cnt <= r_frame_cnt + CW'(1);
    end
  end

  assign bus.word_valid  = !w_empty;
  assign bus.word_data   = w_empty ? 32'd0 : r_mem_data[r_rptr];
  assign bus.word_bytes  = w_empty ? 3'd0  : r_mem_bytes[r_rptr];
  assign bus.word_last   = w_empty ? 1'b0  : r_mem_last[r_rptr];
  assign bus.level       = r_level;
  assign bus.ovf         = r_ovf;
  assign bus.frame_cnt   = r_frame_cnt;
  assign bus.dbg_packing = (r_state == ST_PACKING);
  assign bus.dbg_idx     = r_idx;
endmodule

// File: tb/tb_link_rx_packer.sv
// Bench for link_rx_packer: directed table, hand sequences for overflow/full/reset,
// and random traffic against a queue-based frame model.
module tb_link_rx_packer;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  link_rx_packer_if #(.DEPTH(DEPTH), .CW(CW)) bus ();
  link_rx_packer #(.DEPTH(DEPTH), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  bytes;
    logic        last;
  } word_t;

  typedef struct packed {
    logic          bv;
    logic [7:0]    b;
    logic          last;
    logic          rdy;
    logic          clr;
    logic          e_valid;
    logic [31:0]   e_data;
    logic [2:0]    e_bytes;
    logic          e_last;
    logic [LW-1:0] e_level;
    logic          e_ovf;
    logic [CW-1:0] e_frames;
  } vec_t;

  word_t       exp_q[$];
  logic [7:0]  cur_q[$];
  logic        m_ovf;
  int unsigned m_frames;
  int          n_checks = 0;
  int          n_fail   = 0;
  vec_t        tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    cur_q.delete();
    m_ovf    = 1'b0;
    m_frames = 0;
  endfunction

  // Frame-level model: bytes collect in a list; four bytes or a last byte form a word.
  function automatic void model_tick(input bit bv, input logic [7:0] b, input bit last,
                                     input bit rdy, input bit clr);
    word_t w;
    bit    ovf_now;
    ovf_now = 1'b0;
    if (rdy && exp_q.size() > 0) begin
      if (exp_q[0].last) m_frames++;
      void'(exp_q.pop_front());
    end
    if (bv) begin
      cur_q.push_back(b);
      if (cur_q.size() == 4 || last) begin
        w.data = 32'd0;
        foreach (cur_q[i]) w.data = w.data | (32'(cur_q[i]) << (8 * i));
        w.bytes = 3'(cur_q.size());
        w.last  = last;
        cur_q.delete();
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else ovf_now = 1'b1;
      end
    end
    if (ovf_now) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endfunction

  task automatic cmp_model();
    chk("m_valid", 32'(bus.word_valid), 32'(exp_q.size() != 0));
    chk("m_level", 32'(bus.level), 32'(exp_q.size()));
    chk("m_ovf", 32'(bus.ovf), 32'(m_ovf));
    chk("m_frames", 32'(bus.frame_cnt), m_frames % (32'd1 << CW));
    if (exp_q.size() != 0) begin
      chk("m_data", bus.word_data, exp_q[0].data);
      chk("m_bytes", 32'(bus.word_bytes), 32'(exp_q[0].bytes));
      chk("m_last", 32'(bus.word_last), 32'(exp_q[0].last));
    end
  endtask

  task automatic idle_inputs();
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'd0;
    bus.last_byte  = 1'b0;
    bus.word_ready = 1'b0;
    bus.ovf_clr    = 1'b0;
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input bit bv, input logic [7:0] b, input bit last,
                      input bit rdy, input bit clr);
    @(negedge clk);
    bus.byte_valid = bv;
    bus.byte_in    = b;
    bus.last_byte  = last;
    bus.word_ready = rdy;
    bus.ovf_clr    = clr;
    @(posedge clk);
    #1;
    model_tick(bv, b, last, rdy, clr);
    cmp_model();
  endtask

  initial begin
    logic [31:0] ew;
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 3'd0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 3'd0, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 3'd0, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 32'h44332211, 3'd4, 1'b1, 3'd1, 1'b0, 16'd0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 3'd0, 1'b0, 16'd1};
    tbl[5]  = '{1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000007E, 3'd1, 1'b1, 3'd1, 1'b0, 16'd1};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 3'd0, 1'b0, 16'd2};
    tbl[7]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 3'd0, 1'b0, 16'd2};
    tbl[8]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 3'd0, 1'b0, 16'd2};
    tbl[9]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 3'd0, 1'b0, 16'd2};
    tbl[10] = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA3A2A1A0, 3'd4, 1'b0, 3'd1, 1'b0, 16'd2};
    tbl[11] = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA3A2A1A0, 3'd4, 1'b0, 3'd1, 1'b0, 16'd2};
    tbl[12] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA3A2A1A0, 3'd4, 1'b0, 3'd2, 1'b0, 16'd2};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000A5A4, 3'd2, 1'b1, 3'd1, 1'b0, 16'd2};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 3'd0, 1'b0, 16'd3};

    // Reset values
    idle_inputs();
    model_reset();
    #12;
    chk("rst_valid", 32'(bus.word_valid), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_data", bus.word_data, 32'd0);
    chk("rst_bytes", 32'(bus.word_bytes), 32'd0);
    chk("rst_last", 32'(bus.word_last), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_frames", 32'(bus.frame_cnt), 32'd0);
    chk("rst_idx", 32'(bus.dbg_idx), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].bv, tbl[i].b, tbl[i].last, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("t%0d_valid", i), 32'(bus.word_valid), 32'(tbl[i].e_valid));
      chk($sformatf("t%0d_level", i), 32'(bus.level), 32'(tbl[i].e_level));
      chk($sformatf("t%0d_ovf", i), 32'(bus.ovf), 32'(tbl[i].e_ovf));
      chk($sformatf("t%0d_frames", i), 32'(bus.frame_cnt), 32'(tbl[i].e_frames));
      if (tbl[i].e_valid) begin
        chk($sformatf("t%0d_data", i), bus.word_data, tbl[i].e_data);
        chk($sformatf("t%0d_bytes", i), 32'(bus.word_bytes), 32'(tbl[i].e_bytes));
        chk($sformatf("t%0d_last", i), 32'(bus.word_last), 32'(tbl[i].e_last));
      end
    end

    // Overflow: five full words with no consumer
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 4; j++) step(1'b1, 8'(16 * k + j + 1), 1'b0, 1'b0, 1'b0);
      if (k == 3) chk("ovf_pre", 32'(bus.ovf), 32'd0);
    end
    chk("ovf_level", 32'(bus.level), 32'd4);
    chk("ovf_set", 32'(bus.ovf), 32'd1);
    for (int k = 0; k < 4; k++) begin
      ew = {8'(16 * k + 4), 8'(16 * k + 3), 8'(16 * k + 2), 8'(16 * k + 1)};
      chk($sformatf("drain%0d", k), bus.word_data, ew);
      step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(bus.word_valid), 32'd0);
    chk("ovf_sticky", 32'(bus.ovf), 32'd1);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(bus.ovf), 32'd0);

    // Full FIFO with a pop in the completing cycle
    for (int n = 0; n < 16; n++) step(1'b1, 8'(n + 8'h40), n % 4 == 3, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) step(1'b1, 8'(n + 8'hC0), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
    chk("full_pp_level", 32'(bus.level), 32'd4);
    chk("full_pp_ovf", 32'(bus.ovf), 32'd0);
    for (int n = 0; n < 4; n++) step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    chk("full_pp_tail", 32'(bus.level), 32'd0);

    // Asynchronous reset in the middle of a frame
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    #2;
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("mid_rst_idx", 32'(bus.dbg_idx), 32'd0);
    chk("mid_rst_frames", 32'(bus.frame_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int n = 1; n <= 4; n++) step(1'b1, 8'(n), n == 4, 1'b0, 1'b0);
    chk("mid_rst_data", bus.word_data, 32'h04030201);
    chk("mid_rst_bytes", 32'(bus.word_bytes), 32'd4);
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    chk("mid_rst_cnt", 32'(bus.frame_cnt), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
